demux_1_to_6: RTL and testbench

//   Inverse of the 6-to-1 lab mux: steers one 8-bit input stream to one of six output channels.

---
 rtl/demux_1_to_6_if.sv | 46 ++++
 rtl/demux_1_to_6.sv | 100 ++++++++++
 tb/tb_demux_1_to_6.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_1_to_6_if.sv
// Producer/consumer bundle for the 1-to-6 demux.
// drop_cnt exists only when DEMUX_DROP_CNT_EN is defined.
interface demux_1_to_6_if #(
    parameter int WIDTH = 8
`ifdef DEMUX_DROP_CNT_EN
    , parameter int CNT_W = 8
`endif
);
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic [WIDTH-1:0] out_data4;
    logic [WIDTH-1:0] out_data5;
    logic [5:0]       out_valid;
    logic [5:0]       out_ready;
    logic [2:0]       rr_ptr;
`ifdef DEMUX_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt;
`endif

    modport slave (
        input  in_data, in_sel, in_valid, mode, out_ready,
        output in_ready, out_valid, rr_ptr,
        output out_data0, out_data1, out_data2,
        output out_data3, out_data4, out_data5
`ifdef DEMUX_DROP_CNT_EN
        , output drop_cnt
`endif
    );

    modport master (
        output in_data, in_sel, in_valid, mode, out_ready,
        input  in_ready, out_valid, rr_ptr,
        input  out_data0, out_data1, out_data2,
        input  out_data3, out_data4, out_data5
`ifdef DEMUX_DROP_CNT_EN
        , input drop_cnt
`endif
    );
endinterface

// File: rtl/demux_1_to_6.sv
// 1-to-6 demux with one-entry buffers, explicit or round-robin routing.
// Define DEMUX_DROP_CNT_EN to add the saturating drop counter.
module demux_1_to_6 #(
    parameter int WIDTH = 8
`ifdef DEMUX_DROP_CNT_EN
    , parameter int CNT_W = 8
`endif
) (
    input logic           clk,
    input logic           rst,
    demux_1_to_6_if.slave bus
);
    localparam logic [2:0] LAST = 3'd5;

    logic [WIDTH-1:0] data_q [6];
    logic [WIDTH-1:0] data_d [6];
    logic [5:0]       valid_q;
    logic [5:0]       valid_d;
    logic [2:0]       rr_q;
    logic [2:0]       rr_d;

    logic [2:0] tgt;
    logic       tgt_ok;
    logic [7:0] busy;
    logic       ready;
    logic       push;
    logic [5:0] push_vec;

    always_comb begin
        tgt    = bus.mode ? rr_q : bus.in_sel;
        tgt_ok = tgt < 3'd6;
        // Targets 6/7 index the zero pad, so they always read as ready.
        busy   = {2'b00, valid_q & ~bus.out_ready};
        ready  = ~busy[tgt];
        push   = bus.in_valid & ready & tgt_ok;
        push_vec = '0;
        if (push) begin
            push_vec = 6'd1 << tgt;
        end
    end

    always_comb begin
        valid_d = (valid_q & ~bus.out_ready) | push_vec;
        for (int i = 0; i < 6; i++) begin
            data_d[i] = push_vec[i] ? bus.in_data : data_q[i];
        end
        rr_d = rr_q;
        if (push && bus.mode) begin
            rr_d = (rr_q == LAST) ? 3'd0 : rr_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            rr_q    <= '0;
            for (int i = 0; i < 6; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rr_q    <= rr_d;
            for (int i = 0; i < 6; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    logic [CNT_W-1:0] drop_q;
    logic [CNT_W-1:0] drop_d;

    always_comb begin
        drop_d = drop_q;
        if (bus.in_valid && !tgt_ok && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign bus.drop_cnt = drop_q;
`endif

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.rr_ptr    = rr_q;
    assign bus.out_data0 = data_q[0];
    assign bus.out_data1 = data_q[1];
    assign bus.out_data2 = data_q[2];
    assign bus.out_data3 = data_q[3];
    assign bus.out_data4 = data_q[4];
    assign bus.out_data5 = data_q[5];
endmodule

// File: tb/tb_demux_1_to_6.sv
// Self-checking bench for demux_1_to_6: directed scenarios plus a
// randomized run against a per-beat behavioural model.
module tb_demux_1_to_6;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    demux_1_to_6_if #(.WIDTH(8)
`ifdef DEMUX_DROP_CNT_EN
        , .CNT_W(8)
`endif
    ) bus ();

    demux_1_to_6 #(.WIDTH(8)
`ifdef DEMUX_DROP_CNT_EN
        , .CNT_W(8)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s,
                         input logic [7:0] d, input logic m,
                         input logic [5:0] r);
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.mode      = m;
        bus.out_ready = r;
    endtask

    function automatic logic [7:0] get_data(input int i);
        case (i)
            0: return bus.out_data0;
            1: return bus.out_data1;
            2: return bus.out_data2;
            3: return bus.out_data3;
            4: return bus.out_data4;
            default: return bus.out_data5;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, 3'd0, 8'd0, 1'b0, 6'd0);
        do_reset();
        checks++;
        if (bus.out_valid !== 6'd0) begin
            errors++;
            $display("FAIL reset_valid got %b want 000000", bus.out_valid);
        end
        checks++;
        if (bus.rr_ptr !== 3'd0) begin
            errors++;
            $display("FAIL reset_ptr got %0d want 0", bus.rr_ptr);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (get_data(i) !== 8'd0) begin
                errors++;
                $display("FAIL reset_data%0d got %0d want 0", i, get_data(i));
            end
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", bus.in_ready);
        end
`ifdef DEMUX_DROP_CNT_EN
        checks++;
        if (bus.drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_drop got %0d want 0", bus.drop_cnt);
        end
`endif
    endtask

    task automatic test_explicit();
        drive(1'b1, 3'd2, 8'd30, 1'b0, 6'd0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL expl_ready got %b want 1", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 6'b000100 || bus.out_data2 !== 8'd30) begin
            errors++;
            $display("FAIL expl_push got v=%b d=%0d want v=000100 d=30",
                     bus.out_valid, bus.out_data2);
        end
        drive(1'b1, 3'd2, 8'd31, 1'b0, 6'd0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL expl_full_ready got %b want 0", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_data2 !== 8'd30) begin
            errors++;
            $display("FAIL expl_stall got %0d want 30", bus.out_data2);
        end
        bus.out_ready = 6'b000100;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL expl_pass_ready got %b want 1", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 6'b000100 || bus.out_data2 !== 8'd31) begin
            errors++;
            $display("FAIL expl_second got v=%b d=%0d want v=000100 d=31",
                     bus.out_valid, bus.out_data2);
        end
        drive(1'b0, 3'd2, 8'd0, 1'b0, 6'b000100);
        tick();
        checks++;
        if (bus.out_valid !== 6'd0 || bus.out_data2 !== 8'd31) begin
            errors++;
            $display("FAIL expl_drain got v=%b d=%0d want v=000000 d=31",
                     bus.out_valid, bus.out_data2);
        end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 3'd7, 8'(10 * (i + 1)), 1'b1, 6'h3F);
            #1;
            checks++;
            if (bus.rr_ptr !== 3'(i) || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rr_pre%0d got ptr=%0d rdy=%b want ptr=%0d rdy=1",
                         i, bus.rr_ptr, bus.in_ready, i);
            end
            tick();
            checks++;
            if (bus.out_valid !== 6'(1 << i) || get_data(i) !== 8'(10 * (i + 1))) begin
                errors++;
                $display("FAIL rr_beat%0d got v=%b d=%0d want v=%b d=%0d",
                         i, bus.out_valid, get_data(i), 6'(1 << i), 10 * (i + 1));
            end
        end
        drive(1'b0, 3'd0, 8'd0, 1'b1, 6'h3F);
        tick();
        checks++;
        if (bus.out_valid !== 6'd0 || bus.rr_ptr !== 3'd0) begin
            errors++;
            $display("FAIL rr_end got v=%b ptr=%0d want v=000000 ptr=0",
                     bus.out_valid, bus.rr_ptr);
        end
    endtask

    task automatic test_rr_stall();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 3'd0, 8'(i + 1), 1'b1, 6'd0);
            tick();
        end
        drive(1'b1, 3'd0, 8'd77, 1'b1, 6'd0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready got %b want 0", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 6'h3F || bus.rr_ptr !== 3'd0 || bus.out_data0 !== 8'd1) begin
            errors++;
            $display("FAIL stall_hold got v=%b ptr=%0d d0=%0d want v=111111 ptr=0 d0=1",
                     bus.out_valid, bus.rr_ptr, bus.out_data0);
        end
        drive(1'b0, 3'd0, 8'd0, 1'b1, 6'b001000);
        tick();
        checks++;
        if (bus.out_valid !== 6'b110111) begin
            errors++;
            $display("FAIL stall_drain got %b want 110111", bus.out_valid);
        end
        bus.out_ready = 6'h3F;
        tick();
    endtask

    task automatic test_invalid();
        do_reset();
        drive(1'b1, 3'd7, 8'd99, 1'b0, 6'd0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL inv7_ready got %b want 1", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 6'd0 || bus.rr_ptr !== 3'd0) begin
            errors++;
            $display("FAIL inv7_drop got v=%b ptr=%0d want v=000000 ptr=0",
                     bus.out_valid, bus.rr_ptr);
        end
`ifdef DEMUX_DROP_CNT_EN
        checks++;
        if (bus.drop_cnt !== 8'd1) begin
            errors++;
            $display("FAIL inv7_cnt got %0d want 1", bus.drop_cnt);
        end
`endif
        drive(1'b1, 3'd6, 8'd98, 1'b0, 6'd0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 6'd0) begin
            errors++;
            $display("FAIL inv6_drop got %b want 000000", bus.out_valid);
        end
`ifdef DEMUX_DROP_CNT_EN
        checks++;
        if (bus.drop_cnt !== 8'd2) begin
            errors++;
            $display("FAIL inv6_cnt got %0d want 2", bus.drop_cnt);
        end
        drive(1'b1, 3'd6, 8'd0, 1'b0, 6'd0);
        for (int i = 0; i < 260; i++) begin
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL drop_sat got %0d want 255", bus.drop_cnt);
        end
`endif
    endtask

    task automatic test_pop_push();
        do_reset();
        drive(1'b1, 3'd0, 8'd10, 1'b0, 6'd0);
        tick();
        drive(1'b1, 3'd0, 8'd100, 1'b0, 6'd1);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pp_ready got %b want 1", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 6'd1 || bus.out_data0 !== 8'd100) begin
            errors++;
            $display("FAIL pp_data got v=%b d=%0d want v=000001 d=100",
                     bus.out_valid, bus.out_data0);
        end
        drive(1'b0, 3'd0, 8'd0, 1'b0, 6'd1);
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(1'b1, 3'd0, 8'd1, 1'b1, 6'd0);
        tick();
        drive(1'b1, 3'd1, 8'd11, 1'b0, 6'd0);
        tick();
        bus.in_sel = 3'd3;
        tick();
        bus.in_sel = 3'd5;
        tick();
        checks++;
        if (bus.out_valid !== 6'b101011 || bus.rr_ptr !== 3'd1) begin
            errors++;
            $display("FAIL mr_pre got v=%b ptr=%0d want v=101011 ptr=1",
                     bus.out_valid, bus.rr_ptr);
        end
        bus.in_sel = 3'd2;
        do_reset();
        checks++;
        if (bus.out_valid !== 6'd0 || bus.rr_ptr !== 3'd0 || bus.out_data1 !== 8'd0) begin
            errors++;
            $display("FAIL mr_clear got v=%b ptr=%0d d1=%0d want v=000000 ptr=0 d1=0",
                     bus.out_valid, bus.rr_ptr, bus.out_data1);
        end
        drive(1'b1, 3'd4, 8'd77, 1'b1, 6'd0);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 6'd1 || bus.out_data0 !== 8'd77 || bus.rr_ptr !== 3'd1) begin
            errors++;
            $display("FAIL mr_restart got v=%b d0=%0d ptr=%0d want v=000001 d0=77 ptr=1",
                     bus.out_valid, bus.out_data0, bus.rr_ptr);
        end
    endtask

    task automatic test_random();
        bit       mv [6];
        int       md [6];
        int       ptr;
        int       drop;
        int       tgt;
        bit       rdy;
        logic [5:0] mvec;
        bit       v;
        int       sel;
        int       d;
        bit       m;
        int       r;
        drive(1'b0, 3'd0, 8'd0, 1'b0, 6'd0);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            mv[i] = 0;
            md[i] = 0;
        end
        ptr  = 0;
        drop = 0;
        for (int n = 0; n < 500; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 7);
            d   = $urandom_range(0, 255);
            m   = $urandom_range(0, 1);
            r   = $urandom_range(0, 63);
            drive(v, 3'(sel), 8'(d), m, 6'(r));
            tgt = m ? ptr : sel;
            rdy = (tgt >= 6) ? 1'b1 : (!mv[tgt] || r[tgt]);
            #1;
            checks++;
            if (bus.in_ready !== rdy) begin
                errors++;
                $display("FAIL rnd_ready@%0d got %b want %b", n, bus.in_ready, rdy);
            end
            tick();
            for (int i = 0; i < 6; i++) begin
                if (mv[i] && r[i]) mv[i] = 0;
            end
            if (v && rdy && tgt < 6) begin
                mv[tgt] = 1;
                md[tgt] = d;
                if (m) ptr = (ptr + 1) % 6;
            end
            if (v && tgt >= 6 && drop < 255) drop++;
            for (int i = 0; i < 6; i++) mvec[i] = mv[i];
            checks++;
            if (bus.out_valid !== mvec || bus.rr_ptr !== 3'(ptr)) begin
                errors++;
                $display("FAIL rnd_state@%0d got v=%b ptr=%0d want v=%b ptr=%0d",
                         n, bus.out_valid, bus.rr_ptr, mvec, ptr);
            end
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (get_data(i) !== 8'(md[i])) begin
                    errors++;
                    $display("FAIL rnd_data%0d@%0d got %0d want %0d",
                             i, n, get_data(i), md[i]);
                end
            end
`ifdef DEMUX_DROP_CNT_EN
            checks++;
            if (bus.drop_cnt !== 8'(drop)) begin
                errors++;
                $display("FAIL rnd_drop@%0d got %0d want %0d", n, bus.drop_cnt, drop);
            end
`endif
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(1'b0, 3'd0, 8'd0, 1'b0, 6'd0);
        test_reset();
        test_explicit();
        test_round_robin();
        test_rr_stall();
        test_invalid();
        test_pop_push();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
